keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad (Pmod header) and reports debounced key presses. Strobes one

---
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x4 active-low matrix keypad and reports debounced key presses.
// Latency: key_valid pulses one cycle after the end of the DEBOUNCE-th matching sweep.
// Backpressure: none; key_valid is a single-cycle pulse, key_code holds until the next accept.
module keypad_scanner #(
  parameter int SCAN_DELAY = 1024,
  parameter int DEBOUNCE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DELAY > 1) ? $clog2(SCAN_DELAY) : 1;
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DELAY - 1);
  localparam logic [BW-1:0] DBC_MAX    = BW'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  // Snapshot bit index is 4*col + row; returns the legend printed on that key.
  function automatic logic [3:0] key_map(input logic [3:0] k);
    logic [3:0] v;
    case (k)
      4'd0:  v = 4'h1;
      4'd1:  v = 4'h4;
      4'd2:  v = 4'h7;
      4'd3:  v = 4'h0;
      4'd4:  v = 4'h2;
      4'd5:  v = 4'h5;
      4'd6:  v = 4'h8;
      4'd7:  v = 4'hF;
      4'd8:  v = 4'h3;
      4'd9:  v = 4'h6;
      4'd10: v = 4'h9;
      4'd11: v = 4'hE;
      4'd12: v = 4'hA;
      4'd13: v = 4'hB;
      4'd14: v = 4'hC;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_sync_q, row_sync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic          sweep_q, sweep_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [BW-1:0] dbc_q, dbc_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic [4:0]    hit_cnt;
  logic [3:0]    hit_idx;
  logic          single;
  logic          match;
  logic [BW-1:0] dbc_inc;

  // Column strobe rotation, row synchronizer and per-column snapshot capture.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    dwell_d    = dwell_q + 1'b1;
    cidx_d     = cidx_q;
    col_d      = col_q;
    snap_d     = snap_q;
    sweep_d    = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      cidx_d  = cidx_q + 2'd1;
      col_d   = {col_q[2:0], col_q[3]};
      snap_d[{cidx_q, 2'b00} +: 4] = ~row_sync_q;
      sweep_d = (cidx_q == 2'd3);
    end
  end

  // Classify the completed sweep: count pressed keys and remember which one.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    single  = (hit_cnt == 5'd1);
    match   = single && (hit_idx == cand_q);
    dbc_inc = dbc_q + 1'b1;
  end

  // Debounce FSM: advances only on the cycle after a full sweep completes.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dbc_d   = dbc_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (sweep_q) begin
      case (state_q)
        IDLE: begin
          if (single) begin
            cand_d = hit_idx;
            if (DEBOUNCE <= 1) begin
              state_d = HELD;
              code_d  = key_map(hit_idx);
              valid_d = 1'b1;
              held_d  = 1'b1;
              dbc_d   = '0;
            end else begin
              state_d = PRESS_DB;
              dbc_d   = BW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (match) begin
            if (dbc_inc >= DBC_MAX) begin
              state_d = HELD;
              code_d  = key_map(cand_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_inc;
            end
          end else if (single) begin
            cand_d = hit_idx;
            dbc_d  = BW'(1);
          end else begin
            state_d = IDLE;
            dbc_d   = '0;
          end
        end
        HELD: begin
          if (!match) begin
            if (DEBOUNCE <= 1) begin
              state_d = IDLE;
              held_d  = 1'b0;
              dbc_d   = '0;
            end else begin
              state_d = REL_DB;
              dbc_d   = BW'(1);
            end
          end
        end
        REL_DB: begin
          if (match) begin
            state_d = HELD;
            dbc_d   = '0;
          end else if (dbc_inc >= DBC_MAX) begin
            state_d = IDLE;
            held_d  = 1'b0;
            dbc_d   = '0;
          end else begin
            dbc_d = dbc_inc;
          end
        end
        default: begin
          state_d = IDLE;
          dbc_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; rows reset to released (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      dwell_q    <= '0;
      cidx_q     <= '0;
      col_q      <= 4'b1110;
      snap_q     <= '0;
      sweep_q    <= 1'b0;
      state_q    <= IDLE;
      cand_q     <= '0;
      dbc_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      dwell_q    <= dwell_d;
      cidx_q     <= cidx_d;
      col_q      <= col_d;
      snap_q     <= snap_d;
      sweep_q    <= sweep_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      dbc_q      <= dbc_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed table-driven and sequence checks of keypad_scanner (SCAN_DELAY=8, DEBOUNCE=3).
// Latency: one sweep is 32 cycles; a clean press is accepted on edge 97 after reset release.
// Backpressure: none; the keypad model responds combinationally to the column strobes.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;   // bit 4*c+r set = key at row r, column c pressed

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int valid_in_rst = 0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DELAY(8), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] == 1'b0 && keys[4*c+r]) row[r] = 1'b0;
  end

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (key_valid) pulses++;
    if (rst && key_valid) valid_in_rst++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Holds reset for three edges, then releases it at a falling edge with the given keys.
  task automatic start(input logic [15:0] k);
    rst = 1'b1;
    tick(3);
    keys = k;
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[10];
    logic [3:0] pat[4];
    int p0;
    int held_seen;

    vt[0] = '{r: 2'd0, c: 2'd0, code: 4'h1};
    vt[1] = '{r: 2'd1, c: 2'd1, code: 4'h5};
    vt[2] = '{r: 2'd2, c: 2'd2, code: 4'h9};
    vt[3] = '{r: 2'd3, c: 2'd3, code: 4'hD};
    vt[4] = '{r: 2'd3, c: 2'd0, code: 4'h0};
    vt[5] = '{r: 2'd0, c: 2'd3, code: 4'hA};
    vt[6] = '{r: 2'd3, c: 2'd1, code: 4'hF};
    vt[7] = '{r: 2'd3, c: 2'd2, code: 4'hE};
    vt[8] = '{r: 2'd2, c: 2'd3, code: 4'hC};
    vt[9] = '{r: 2'd1, c: 2'd0, code: 4'h4};
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    // 1: reset state and column strobe sequence with no key pressed
    p0 = pulses;
    start(16'h0000);
    chk("rst_col", 32'(col), 32'(4'b1110));
    chk("rst_code", 32'(key_code), 0);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_held", 32'(key_held), 0);
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      chk($sformatf("col_seq_%0d", n), 32'(col), 32'(pat[(n / 8) % 4]));
    end
    tick(160);
    chk("idle_pulses", 32'(pulses - p0), 0);
    chk("idle_held", 32'(key_held), 0);
    chk("idle_code", 32'(key_code), 0);

    // Key map table: each key accepted once with its legend, released after 3 clean sweeps
    for (int i = 0; i < 10; i++) begin
      logic [15:0] k;
      k = '0;
      k[4*vt[i].c + vt[i].r] = 1'b1;
      p0 = pulses;
      start(k);
      tick(97);
      chk($sformatf("map%0d_valid", i), 32'(key_valid), 1);
      chk($sformatf("map%0d_code", i), 32'(key_code), 32'(vt[i].code));
      chk($sformatf("map%0d_held", i), 32'(key_held), 1);
      keys = '0;
      tick(100);
      chk($sformatf("map%0d_rel_held", i), 32'(key_held), 0);
      chk($sformatf("map%0d_rel_code", i), 32'(key_code), 32'(vt[i].code));
      chk($sformatf("map%0d_pulses", i), 32'(pulses - p0), 1);
    end

    // 2: key '5' held stable, exact pulse timing
    p0 = pulses;
    start(16'h0020);
    tick(96);
    chk("k5_early_valid", 32'(key_valid), 0);
    chk("k5_early_pulses", 32'(pulses - p0), 0);
    tick(1);
    chk("k5_valid", 32'(key_valid), 1);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_held", 32'(key_held), 1);
    tick(1);
    chk("k5_valid_drop", 32'(key_valid), 0);
    tick(50);
    chk("k5_still_held", 32'(key_held), 1);
    chk("k5_pulses", 32'(pulses - p0), 1);

    // 3: bouncing '9': 2 pressed, 1 released, then stable
    p0 = pulses;
    start(16'h0400);
    tick(64);
    keys = '0;
    tick(32);
    keys = 16'h0400;
    tick(96);
    chk("k9_no_early", 32'(pulses - p0), 0);
    tick(1);
    chk("k9_valid", 32'(key_valid), 1);
    chk("k9_code", 32'(key_code), 32'h9);
    tick(10);
    chk("k9_pulses", 32'(pulses - p0), 1);

    // 4: '1' and '2' together for 10 sweeps
    p0 = pulses;
    held_seen = 0;
    start(16'h0011);
    for (int n = 0; n < 320; n++) begin
      tick(1);
      if (key_held) held_seen++;
    end
    chk("multi_pulses", 32'(pulses - p0), 0);
    chk("multi_held_cycles", 32'(held_seen), 0);

    // 5: 'D' held, one-sweep release glitch, then full release and re-press
    p0 = pulses;
    start(16'h8000);
    tick(97);
    chk("kd_valid", 32'(key_valid), 1);
    chk("kd_code", 32'(key_code), 32'hD);
    keys = '0;
    tick(31);
    keys = 16'h8000;
    held_seen = 0;
    for (int n = 0; n < 96; n++) begin
      tick(1);
      if (!key_held) held_seen++;
    end
    chk("kd_glitch_drops", 32'(held_seen), 0);
    chk("kd_glitch_pulses", 32'(pulses - p0), 1);
    keys = '0;
    tick(96);
    chk("kd_rel_pending_held", 32'(key_held), 1);
    tick(1);
    chk("kd_rel_held", 32'(key_held), 0);
    chk("kd_rel_code", 32'(key_code), 32'hD);
    keys = 16'h8000;
    tick(95);
    chk("kd_repress_early", 32'(pulses - p0), 1);
    tick(1);
    chk("kd_repress_valid", 32'(key_valid), 1);
    chk("kd_repress_pulses", 32'(pulses - p0), 2);

    // 6: reset while HELD
    tick(5);
    chk("pre_rst_held", 32'(key_held), 1);
    rst = 1'b1;
    tick(1);
    chk("rst_held_col", 32'(col), 32'(4'b1110));
    chk("rst_held_held", 32'(key_held), 0);
    chk("rst_held_code", 32'(key_code), 0);
    chk("rst_held_valid", 32'(key_valid), 0);
    tick(2);
    rst = 1'b0;
    tick(7);
    chk("post_rst_dwell", 32'(col), 32'(4'b1110));
    tick(1);
    chk("post_rst_step", 32'(col), 32'(4'b1101));
    chk("valid_in_rst", 32'(valid_in_rst), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
